// File: rtl/uart_tx_ticked_if.sv
// Transmit handshake bundle between a TX FIFO/controller and uart_tx_ticked.
//   tx_start     : request to send data_in (level, sampled only while idle)
//   data_in      : word to transmit, captured when the frame is accepted
//   tx_done_tick : one-clock pulse at the end of the stop bit
interface uart_tx_ticked_if #(
    parameter int unsigned DATA_SIZE = 8
);
    logic                 tx_start;
    logic [DATA_SIZE-1:0] data_in;
    logic                 tx_done_tick;

    // Controller side
    modport master (
        output tx_start,
        output data_in,
        input  tx_done_tick
    );

    // Transmitter side
    modport slave (
        input  tx_start,
        input  data_in,
        output tx_done_tick
    );
endinterface

// File: rtl/uart_tx_ticked.sv
// UART transmitter with a built-in oversampling tick generator.
// Frame: start bit, DATA_SIZE data bits LSB first, stop bit of STOP_TICKS ticks.
// Each start/data bit lasts SAMPLE ticks; one tick = BAUD_DVSR system clocks.
// BAUD_DVSR = SYS_FREQ/(SAMPLE*BAUD_RATE) must be at least 2.
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high
//   bus    : handshake (tx_start, data_in in; tx_done_tick out)
//   tx     : serial line, idle high
//   s_tick : one-clock oversampling tick, exported for debug / RX sharing
module uart_tx_ticked #(
    parameter int unsigned DATA_SIZE  = 8,
    parameter int unsigned SYS_FREQ   = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned SAMPLE     = 16,
    parameter int unsigned STOP_TICKS = 16
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_ticked_if.slave  bus,
    output logic             tx,
    output logic             s_tick
);
    localparam int unsigned BAUD_DVSR = SYS_FREQ / (SAMPLE * BAUD_RATE);
    localparam int unsigned CW        = $clog2(BAUD_DVSR);
    localparam int unsigned SW        = $clog2(STOP_TICKS);
    localparam int unsigned NW        = $clog2(DATA_SIZE + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 tick_q, tick_d;
    logic [SW-1:0]        s_q, s_d;
    logic [NW-1:0]        n_q, n_d;
    logic [DATA_SIZE-1:0] b_q, b_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;

    // Tick divider; tick_q is high exactly while cnt_q == BAUD_DVSR-1
    always_comb begin
        cnt_d  = (cnt_q == CW'(BAUD_DVSR - 1)) ? '0 : cnt_q + CW'(1);
        tick_d = (cnt_d == CW'(BAUD_DVSR - 1));
    end

    // Next-state logic; tx_d anticipates the state being entered
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        tx_d    = tx_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                // Acceptance does not wait for a tick
                if (bus.tx_start) begin
                    b_d     = bus.data_in;
                    s_d     = '0;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end

            START: begin
                tx_d = 1'b0;
                if (tick_q) begin
                    if (s_q == SW'(SAMPLE - 1)) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = DATA;
                        tx_d    = b_q[0];
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end

            DATA: begin
                tx_d = b_q[0];
                if (tick_q) begin
                    if (s_q == SW'(SAMPLE - 1)) begin
                        s_d = '0;
                        b_d = b_q >> 1;
                        if (n_q == NW'(DATA_SIZE - 1)) begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end else begin
                            n_d  = n_q + NW'(1);
                            tx_d = b_d[0];
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end

            STOP: begin
                tx_d = 1'b1;
                if (tick_q) begin
                    if (s_q == SW'(STOP_TICKS - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign tx               = tx_q;
    assign s_tick           = tick_q;
    assign bus.tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx_ticked.sv
// Bench for uart_tx_ticked: default 8N1 instance plus a DATA_SIZE=7,
// STOP_TICKS=32 instance. Expected line bits are queued at stimulus time
// and popped as the monitor samples each bit centre.
module tb_uart_tx_ticked;
    localparam int DVSR     = 27;
    localparam int BIT_CLKS = 16 * DVSR;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic tx0, tx7, tick0, tick7;

    int n_pass  = 0;
    int n_total = 0;

    logic exp_q[$];

    // Independent tick model, same reset as the DUTs
    int   m_cnt = 0;
    logic mdl_tick;

    uart_tx_ticked_if #(.DATA_SIZE(8)) bus0 ();
    uart_tx_ticked_if #(.DATA_SIZE(7)) bus7 ();

    uart_tx_ticked dut0 (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus0),
        .tx     (tx0),
        .s_tick (tick0)
    );

    uart_tx_ticked #(.DATA_SIZE(7), .STOP_TICKS(32)) dut7 (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus7),
        .tx     (tx7),
        .s_tick (tick7)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) m_cnt <= 0;
        else       m_cnt <= (m_cnt == DVSR - 1) ? 0 : m_cnt + 1;
    end
    assign mdl_tick = (m_cnt == DVSR - 1);

    function automatic logic line(input int sel);
        return (sel != 0) ? tx7 : tx0;
    endfunction

    function automatic logic done(input int sel);
        return (sel != 0) ? bus7.tx_done_tick : bus0.tx_done_tick;
    endfunction

    task automatic push_frame(input int dsz, input logic [7:0] data);
        exp_q.push_back(1'b0);
        for (int i = 0; i < dsz; i++) exp_q.push_back(data[i]);
        exp_q.push_back(1'b1);
    endtask

    // Waits for a start bit, then checks every bit of the frame and the done pulse
    task automatic capture_frame(input int sel, input int dsz, input int stop_clks,
                                 input string nm, output int wait_cyc);
        int   ticks, start_len, glitch, dones, bad_stop;
        logic ref_v, mid_v, exp_b;
        wait_cyc = 0;
        while (line(sel) !== 1'b0 && wait_cyc < 6000) begin
            @(negedge clk);
            wait_cyc++;
        end
        n_total++;
        if (line(sel) !== 1'b0) begin
            $display("FAIL %s_start_seen: tx=%b after %0d clocks, required 0", nm, line(sel), wait_cyc);
            exp_q.delete();
            return;
        end
        n_pass++;

        ticks = 0; start_len = 0; glitch = 0; dones = 0; mid_v = 1'b1; ref_v = 1'b0;
        forever begin
            if (line(sel) !== 1'b0) glitch++;
            if (done(sel)) dones++;
            start_len++;
            if (mdl_tick) begin
                ticks++;
                if (ticks == 8) mid_v = line(sel);
            end
            if (ticks == 16 || start_len > 2 * BIT_CLKS) break;
            @(negedge clk);
        end
        exp_b = exp_q.pop_front();
        n_total++;
        if (mid_v !== exp_b) $display("FAIL %s_start_bit: got %b required %b", nm, mid_v, exp_b);
        else n_pass++;
        n_total++;
        if (start_len < 15 * DVSR + 1 || start_len > BIT_CLKS)
            $display("FAIL %s_start_len: got %0d clocks required %0d..%0d", nm, start_len, 15 * DVSR + 1, BIT_CLKS);
        else n_pass++;

        for (int k = 0; k < dsz; k++) begin
            for (int j = 0; j < BIT_CLKS; j++) begin
                @(negedge clk);
                if (j == 0) ref_v = line(sel);
                else if (line(sel) !== ref_v) glitch++;
                if (done(sel)) dones++;
                if (j == BIT_CLKS / 2) mid_v = line(sel);
            end
            exp_b = exp_q.pop_front();
            n_total++;
            if (mid_v !== exp_b) $display("FAIL %s_bit%0d: got %b required %b", nm, k, mid_v, exp_b);
            else n_pass++;
        end
        n_total++;
        if (glitch != 0) $display("FAIL %s_bit_stable: %0d off-value clocks, required 0", nm, glitch);
        else n_pass++;

        bad_stop = 0;
        for (int j = 0; j < stop_clks; j++) begin
            @(negedge clk);
            if (line(sel) !== 1'b1) bad_stop++;
            if (done(sel)) dones++;
            if (j == stop_clks / 2) mid_v = line(sel);
        end
        exp_b = exp_q.pop_front();
        n_total++;
        if (mid_v !== exp_b) $display("FAIL %s_stop_bit: got %b required %b", nm, mid_v, exp_b);
        else n_pass++;
        n_total++;
        if (bad_stop != 0) $display("FAIL %s_stop_len: %0d low clocks in stop, required 0", nm, bad_stop);
        else n_pass++;
        n_total++;
        if (dones != 0) $display("FAIL %s_early_done: %0d done pulses inside frame, required 0", nm, dones);
        else n_pass++;

        @(negedge clk);
        n_total++;
        if (done(sel) !== 1'b1) $display("FAIL %s_done: got %b required 1", nm, done(sel));
        else n_pass++;
    endtask

    task automatic pulse_start0(input logic [7:0] data);
        @(negedge clk);
        bus0.data_in  = data;
        bus0.tx_start = 1'b1;
        @(negedge clk);
        bus0.tx_start = 1'b0;
    endtask

    task automatic test_reset();
        int mism, pulses, wide, low, dn;
        logic prev;
        reset = 1'b1;
        repeat (DVSR) @(negedge clk);
        n_total++;
        if (tx0 !== 1'b1 || tx7 !== 1'b1) $display("FAIL rst_tx: got %b/%b required 1/1", tx0, tx7);
        else n_pass++;
        n_total++;
        if (bus0.tx_done_tick !== 1'b0 || bus7.tx_done_tick !== 1'b0)
            $display("FAIL rst_done: got %b/%b required 0/0", bus0.tx_done_tick, bus7.tx_done_tick);
        else n_pass++;
        n_total++;
        if (tick0 !== 1'b0) $display("FAIL rst_tick: got %b required 0", tick0);
        else n_pass++;
        reset = 1'b0;
        mism = 0; pulses = 0; wide = 0; low = 0; dn = 0; prev = 1'b0;
        for (int i = 0; i < 10 * DVSR; i++) begin
            @(negedge clk);
            if (tick0 !== mdl_tick || tick7 !== mdl_tick) mism++;
            if (tick0 === 1'b1) pulses++;
            if (tick0 === 1'b1 && prev === 1'b1) wide++;
            prev = tick0;
            if (tx0 !== 1'b1) low++;
            if (bus0.tx_done_tick !== 1'b0) dn++;
        end
        n_total++;
        if (mism != 0) $display("FAIL tick_phase: %0d mismatching clocks, required 0", mism);
        else n_pass++;
        n_total++;
        if (pulses != 10) $display("FAIL tick_count: got %0d pulses required 10", pulses);
        else n_pass++;
        n_total++;
        if (wide != 0) $display("FAIL tick_width: %0d multi-clock pulses, required 0", wide);
        else n_pass++;
        n_total++;
        if (low != 0 || dn != 0) $display("FAIL idle_line: low=%0d done=%0d required 0/0", low, dn);
        else n_pass++;
    endtask

    task automatic test_single_frame();
        int w;
        push_frame(8, 8'hB3);
        pulse_start0(8'hB3);
        capture_frame(0, 8, BIT_CLKS, "b3", w);
        @(negedge clk);
        n_total++;
        if (bus0.tx_done_tick !== 1'b0 || tx0 !== 1'b1)
            $display("FAIL b3_done_width: done=%b tx=%b required 0/1", bus0.tx_done_tick, tx0);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int w, low;
        @(negedge clk);
        bus0.data_in  = 8'h55;
        bus0.tx_start = 1'b1;
        for (int f = 0; f < 3; f++) begin
            push_frame(8, 8'h55);
            capture_frame(0, 8, BIT_CLKS, "b2b", w);
            if (f == 2) bus0.tx_start = 1'b0;
            if (f > 0) begin
                n_total++;
                if (w != 1) $display("FAIL b2b_gap%0d: got %0d clocks required 1", f, w);
                else n_pass++;
            end
        end
        low = 0;
        repeat (500) begin
            @(negedge clk);
            if (tx0 !== 1'b1) low++;
        end
        n_total++;
        if (low != 0) $display("FAIL b2b_release: %0d low clocks after release, required 0", low);
        else n_pass++;
    endtask

    task automatic test_data_hold();
        int w;
        push_frame(8, 8'hFF);
        pulse_start0(8'hFF);
        fork
            capture_frame(0, 8, BIT_CLKS, "hold", w);
            begin
                repeat (1000) @(negedge clk);
                bus0.data_in = 8'h00;
            end
        join
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        int w, low, dn;
        pulse_start0(8'hB3);
        repeat (1500) @(negedge clk);
        n_total++;
        if (tx0 !== 1'b0) $display("FAIL abort_pre: got %b required 0 (bit2 of B3)", tx0);
        else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        n_total++;
        if (tx0 !== 1'b1 || bus0.tx_done_tick !== 1'b0)
            $display("FAIL abort_tx: tx=%b done=%b required 1/0", tx0, bus0.tx_done_tick);
        else n_pass++;
        reset = 1'b0;
        low = 0; dn = 0;
        repeat (600) begin
            @(negedge clk);
            if (tx0 !== 1'b1) low++;
            if (bus0.tx_done_tick !== 1'b0) dn++;
        end
        n_total++;
        if (low != 0 || dn != 0) $display("FAIL abort_idle: low=%0d done=%0d required 0/0", low, dn);
        else n_pass++;
        push_frame(8, 8'h3C);
        pulse_start0(8'h3C);
        capture_frame(0, 8, BIT_CLKS, "post", w);
        @(negedge clk);
    endtask

    task automatic test_param_frame();
        int w;
        push_frame(7, 8'h5B);
        @(negedge clk);
        bus7.data_in  = 7'h5B;
        bus7.tx_start = 1'b1;
        @(negedge clk);
        bus7.tx_start = 1'b0;
        capture_frame(1, 7, 2 * BIT_CLKS, "p7", w);
        @(negedge clk);
        n_total++;
        if (bus7.tx_done_tick !== 1'b0 || tx7 !== 1'b1)
            $display("FAIL p7_done_width: done=%b tx=%b required 0/1", bus7.tx_done_tick, tx7);
        else n_pass++;
    endtask

    initial begin
        bus0.tx_start = 1'b0;
        bus0.data_in  = '0;
        bus7.tx_start = 1'b0;
        bus7.data_in  = '0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_data_hold();
        test_reset_mid_frame();
        test_param_frame();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_tx_ticked.md
Name: uart_tx_ticked

Overview:
UART transmitter with an integrated oversampling tick generator. It serializes one DATA_SIZE-bit word per frame onto a single line, in 8N1 format by default: start bit, data bits LSB first, one stop bit. Each bit lasts SAMPLE oversampling ticks, and the ticks are derived from the system clock. It sits between a transmit FIFO/controller and the serial pin.

Parameters:
DATA_SIZE, 8, number of data bits per frame
SYS_FREQ, 50000000, system clock frequency in Hz
BAUD_RATE, 115200, serial bit rate
SAMPLE, 16, oversampling ticks per bit
STOP_TICKS, 16, ticks in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2)
BAUD_DVSR, SYS_FREQ/(SAMPLE*BAUD_RATE), clocks per tick (integer division; 27 at defaults)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
tx_start  input  1  request to send data_in; level-sampled in IDLE only
data_in  input  DATA_SIZE  word to transmit; captured on frame acceptance
tx  output  1  serial line, idle high
tx_done_tick  output  1  one-clock pulse at end of stop bit
s_tick  output  1  one-clock oversampling tick, exported for debug and RX sharing

Behaviour:
Interface
- One clock; reset is synchronous and active-high.

Tick generator
- Free-running counter of width $clog2(BAUD_DVSR), counting 0..BAUD_DVSR-1 and then wrapping to 0.
- s_tick is high for exactly one clock when the counter equals BAUD_DVSR-1, giving a period of BAUD_DVSR clocks.
- Counter and s_tick are 0 during and right after reset.
- BAUD_DVSR must be at least 2.

Transmit FSM
- States: IDLE, START, DATA, STOP.
- Registers:
  - tick counter s, width $clog2(STOP_TICKS)
  - bit counter n, width $clog2(DATA_SIZE+1)
  - shift register b, width DATA_SIZE
  - tx_reg

IDLE
- tx = 1.
- If tx_start = 1 at a clock edge: b <= data_in, s <= 0, go to START.
- This acceptance does not wait for s_tick.

START
- tx = 0.
- On each s_tick: if s = SAMPLE-1, then s <= 0, n <= 0, go to DATA; else s <= s+1.

DATA
- tx = b[0].
- On each s_tick: if s = SAMPLE-1, then s <= 0, b <= b >> 1, and:
  - if n = DATA_SIZE-1, go to STOP;
  - else n <= n+1.
- Otherwise s <= s+1.

STOP
- tx = 1.
- On each s_tick: if s = STOP_TICKS-1, go to IDLE and assert tx_done_tick for that single clock; else s <= s+1.

Output timing
- tx is registered: tx_reg takes the value of the state being entered on the same edge as the transition. tx therefore goes low on the clock edge that accepts tx_start.
- Start bit: exactly SAMPLE s_ticks; its length in clocks is (SAMPLE-1)*BAUD_DVSR+1 to SAMPLE*BAUD_DVSR, depending on tick phase.
- Each data bit: exactly SAMPLE*BAUD_DVSR clocks (432 at defaults).
- Stop bit: STOP_TICKS*BAUD_DVSR clocks.

Back-to-back and input handling
- If tx_start is still high in IDLE after tx_done_tick, the next frame starts one clock later. The stop-bit time is always complete.
- tx_start and data_in are ignored outside IDLE; data_in changes mid-frame do not affect the frame.

Reset
- Reset forces state IDLE, tx = 1, tx_done_tick = 0, s = 0, n = 0, b = 0, tick counter = 0.
- Reset mid-frame aborts immediately; tx is high on the next clock.

Test Plan:
1. Reset held 27 clocks, then released -> tx = 1, tx_done_tick = 0, s_tick pulses every 27 clocks, each pulse 1 clock wide.
2. data_in = 8'hB3, tx_start pulsed 1 clock ->
   - tx bit sequence: 0 (start), 1,1,0,0,1,1,0,1 (LSB first), 1 (stop);
   - each data bit lasts 432 clocks;
   - tx_done_tick is a single 1-clock pulse about 4320 clocks after start.
3. tx_start held high continuously with data_in = 8'h55 ->
   - frames repeat back to back;
   - each frame's stop bit is a full 432 clocks;
   - tx_done_tick fires once per frame;
   - next start bit begins one clock after the pulse.
4. data_in changed to 8'h00 during DATA of a frame sending 8'hFF -> all 8 data bits are still 1.
5. reset asserted mid-DATA -> tx = 1 on next clock, FSM in IDLE, no tx_done_tick. A new tx_start afterwards sends a correct frame.
6. Parameters STOP_TICKS = 32, DATA_SIZE = 7 -> 7 data bits, stop bit of 864 clocks, tx_done_tick at end of stop.
